codec_init_sequencer: RTL and testbench

- Upstream command source for the I2C master (i2c_comms) in the audio pipeline.
- After reset it waits out the codec power-up time, then walks a fixed table of 16-bit WM8731 register writes.
- Each entry is handed to the I2C master over a valid/ready command channel, and the sequencer waits for the master's ACK/NACK response.
- On completion it raises init_done, which releases the downstream I2S/audio path.

---
 rtl/codec_init_sequencer.sv | 114 +++++++++++
 tb/tb_codec_init_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: power-up wait, then writes the WM8731 register table over a valid/ready I2C command channel.
// Define INIT_TIMEOUT_EN to add a WAIT_RSP watchdog that treats a missing response as a NACK.
module codec_init_sequencer #(
  parameter int POWERUP_DELAY_CYCLES = 1_000_000,
  parameter int GAP_CYCLES = 1000,
  parameter int MAX_RETRIES = 3,
  parameter int RSP_TIMEOUT_CYCLES = 100_000,
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_dev_addr,
  output logic [15:0] cmd_word,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  output logic        init_done,
  output logic        init_error,
  output logic        busy,
  output logic [3:0]  entry_idx
);
  localparam int MAX_A = POWERUP_DELAY_CYCLES > GAP_CYCLES ? POWERUP_DELAY_CYCLES : GAP_CYCLES;
  localparam int MAX_C = MAX_A > RSP_TIMEOUT_CYCLES ? MAX_A : RSP_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);
  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic [2:0] {PWR_WAIT, ISSUE, WAIT_RSP, GAP, DONE, ERROR} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry_cnt, retry_n;
  logic [3:0] idx_n;
  logic rsp_hit, nack;

  function automatic logic [15:0] rom(input logic [3:0] i);
    case (i)
      4'd0:  rom = 16'h1E00;
      4'd1:  rom = 16'h0C10;
      4'd2:  rom = 16'h0017;
      4'd3:  rom = 16'h0217;
      4'd4:  rom = 16'h0479;
      4'd5:  rom = 16'h0679;
      4'd6:  rom = 16'h0812;
      4'd7:  rom = 16'h0A00;
      4'd8:  rom = 16'h0E02;
      4'd9:  rom = 16'h1000;
      4'd10: rom = 16'h1201;
      4'd11: rom = 16'h0C00;
      default: rom = 16'h0000;
    endcase
  endfunction

`ifdef INIT_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(RSP_TIMEOUT_CYCLES - 1);
  // a real response in the timeout cycle takes precedence
  assign rsp_hit = rsp_valid || cnt == TO_LAST;
  assign nack = rsp_valid ? rsp_nack : 1'b1;
`else
  assign rsp_hit = rsp_valid;
  assign nack = rsp_nack;
`endif

  assign cmd_valid = state == ISSUE;
  assign cmd_word = cmd_valid ? rom(entry_idx) : 16'h0000;
  assign cmd_dev_addr = DEV_ADDR;
  assign init_done = state == DONE;
  assign init_error = state == ERROR;
  assign busy = !(init_done || init_error);

  always_comb begin
    state_n = state;
    idx_n = entry_idx;
    retry_n = retry_cnt;
    case (state)
      PWR_WAIT: if (cnt == PWR_LAST) begin
        state_n = ISSUE;
        idx_n = '0;
      end
      ISSUE: state_n = cmd_ready ? WAIT_RSP : ISSUE;
      WAIT_RSP: if (rsp_hit) begin
        retry_n = nack ? retry_cnt + 1'b1 : '0;
        state_n = nack ? (retry_n == RMAX ? ERROR : GAP) : (entry_idx == LAST_IDX ? DONE : GAP);
        idx_n = (nack || entry_idx == LAST_IDX) ? entry_idx : entry_idx + 4'd1;
      end
      GAP: state_n = cnt == GAP_LAST ? ISSUE : GAP;
      default: if (start) begin
        state_n = ISSUE;
        idx_n = '0;
        retry_n = '0;
      end
    endcase
  end

  // one shared counter serves power-up, gap and watchdog; it clears on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PWR_WAIT;
      cnt <= '0;
      retry_cnt <= '0;
      entry_idx <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      retry_cnt <= retry_n;
      entry_idx <= idx_n;
    end
  end
endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb_codec_init_sequencer: scoreboarded directed test of the codec init sequencer with a modelled I2C master.
module tb_codec_init_sequencer;
  logic clk = 0, rst, start, cmd_valid, cmd_ready, rsp_valid, rsp_nack;
  logic init_done, init_error, busy;
  logic [6:0] cmd_dev_addr;
  logic [15:0] cmd_word;
  logic [3:0] entry_idx;
  int checks = 0, errors = 0, hs_cnt = 0;
  bit rsp_en;
  logic [15:0] exp_q[$];
  bit nack_q[$];

  localparam logic [15:0] TBL [12] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                       16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201, 16'h0C00};

  codec_init_sequencer #(
    .POWERUP_DELAY_CYCLES(16), .GAP_CYCLES(4), .MAX_RETRIES(3), .RSP_TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_word(cmd_word), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .init_done(init_done), .init_error(init_error), .busy(busy), .entry_idx(entry_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_table;
    for (int i = 0; i < 12; i++) exp_q.push_back(TBL[i]);
  endtask

  task automatic pulse_start;
    tick;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic wait_idx(input logic [3:0] idx, input bit need_valid, input string nm);
    int n = 0;
    while (!(entry_idx == idx && (cmd_valid || !need_valid)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 2000, 1);
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (!init_done && !init_error && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 2000, 1);
  endtask

  task automatic pwr_latency(input string nm);
    int n = 0;
    while (!cmd_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 5) start = 1;
      if (n == 6) start = 0;
    end
    chk(nm, n >= 16 && n <= 17, 1);
  endtask

  // scoreboard monitor: every handshake must match the next expected word
  initial forever begin
    @(negedge clk);
    if (rst && cmd_valid && cmd_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got %h expected none", cmd_word);
      end else begin
        chk("cmd_word", cmd_word, exp_q.pop_front());
        chk("cmd_dev_addr", cmd_dev_addr, 7'h1A);
      end
    end
  end

  // I2C master model: answers each accepted command 10 cycles later
  initial begin
    bit nk;
    rsp_valid = 0;
    rsp_nack = 0;
    forever begin
      @(negedge clk);
      if (rst && rsp_en && cmd_valid && cmd_ready) begin
        nk = 0;
        if (nack_q.size() != 0) nk = nack_q.pop_front();
        repeat (11) @(posedge clk);
        #1 rsp_valid = 1;
        rsp_nack = nk;
        @(posedge clk);
        #1 rsp_valid = 0;
        rsp_nack = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, hs0;
    rst = 0; start = 0; cmd_ready = 1; rsp_en = 1;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_word", cmd_word, 0);
    chk("rst_dev_addr", cmd_dev_addr, 7'h1A);
    chk("rst_done", init_done, 0);
    chk("rst_error", init_error, 0);
    chk("rst_busy", busy, 1);
    chk("rst_idx", entry_idx, 0);
    push_table;
    tick;
    rst = 1;
    pwr_latency("pwr_latency");
    wait_idx(3, 0, "reach_e3");
    cmd_ready = 0;
    wait_idx(3, 1, "e3_valid");
    hs0 = hs_cnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cmd_valid || cmd_word !== 16'h0217) bad++;
      @(negedge clk);
    end
    chk("bp_stable", bad, 0);
    tick;
    cmd_ready = 1;
    wait_idx(4, 0, "reach_e4");
    chk("bp_one_hs", hs_cnt - hs0, 1);
    wait_end("nominal_end");
    chk("nom_done", init_done, 1);
    chk("nom_busy", busy, 0);
    chk("nom_error", init_error, 0);
    chk("nom_idx", entry_idx, 11);
    chk("nom_hs", hs_cnt, 12);
    chk("nom_q_empty", exp_q.size(), 0);

    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(TBL[i]);
      if (i == 5) begin
        exp_q.push_back(TBL[5]);
        exp_q.push_back(TBL[5]);
      end
    end
    nack_q = '{0, 0, 0, 0, 0, 1, 1};
    pulse_start;
    @(negedge clk);
    chk("start_done_issue", cmd_valid, 1);
    chk("start_clears_done", init_done, 0);
    wait_idx(5, 1, "e5_valid");
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
      chk("e5_rsp_seen", n < 50, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_valid && n < 50);
      chk("gap_latency", n, 5);
    end
    wait_end("nack_end");
    chk("nack_done", init_done, 1);
    chk("nack_q_empty", exp_q.size(), 0);

    exp_q = '{TBL[0], TBL[1], TBL[2], TBL[2], TBL[2]};
    nack_q = '{0, 0, 1, 1, 1};
    pulse_start;
    wait_end("retry_end");
    chk("retry_error", init_error, 1);
    chk("retry_done", init_done, 0);
    chk("retry_idx", entry_idx, 2);
    chk("retry_busy", busy, 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_valid) bad++;
    end
    chk("no_cmd_after_error", bad, 0);
    push_table;
    pulse_start;
    @(negedge clk);
    chk("start_clears_error", init_error, 0);
    chk("start_err_issue", cmd_valid, 1);
    chk("start_err_idx", entry_idx, 0);

    wait_idx(7, 1, "e7_valid");
    @(negedge clk);
    chk("e7_wait_rsp", cmd_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_done", init_done, 0);
    chk("mid_rst_idx", entry_idx, 0);
    chk("mid_rst_busy", busy, 1);
    exp_q.delete();
    nack_q.delete();
    repeat (3) tick;
    push_table;
    rst = 1;
    pwr_latency("pwr_latency_again");
    wait_end("rerun_end");
    chk("rerun_done", init_done, 1);

    rsp_en = 0;
`ifdef INIT_TIMEOUT_EN
    exp_q = '{TBL[0], TBL[0], TBL[0]};
    pulse_start;
    @(negedge clk);
    @(negedge clk);
    chk("to_wait_rsp", cmd_valid, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_valid && n < 200);
    chk("to_reissue", n, 68);
    wait_end("to_end");
    chk("to_error", init_error, 1);
    chk("to_idx", entry_idx, 0);
`else
    exp_q = '{TBL[0]};
    pulse_start;
    @(negedge clk);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cmd_valid || !busy || init_done || init_error) bad++;
    end
    chk("no_timeout_hold", bad, 0);
`endif
    chk("final_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
